// File: rtl/ahb_cmd_sequencer.sv
// Command-table driven AHB transaction sequencer feeding ahbtop.
// Optional feature: define SEQ_LOOP_EN to replay the table continuously until reset.
module ahb_cmd_sequencer #(
  parameter int NCMD = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_idx,
  input  logic [23:0] cmd_wdata,
  input  logic        start,
  input  logic        hready,
  input  logic [7:0]  rdata,
  output logic [7:0]  data,
  output logic [10:0] address,
  output logic        write,
  output logic [2:0]  bursttype,
  output logic        valid,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rd_sum
);

`ifdef SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, BEAT, DONE} state_t;

  state_t      state, state_next;
  logic [23:0] cmd_table [NCMD];
  logic [23:0] entry;
  logic [3:0]  ptr;
  logic [2:0]  beat_cnt;
  logic        cur_last;
  logic        pending;
  logic        accept, final_beat, seq_end;

  // Remaining beats after the first; reserved encodings play as SINGLE.
  function automatic logic [2:0] beats_minus_one(input logic [2:0] b);
    case (b)
      3'b001:         return 3'd1;
      3'b010, 3'b011: return 3'd3;
      3'b100, 3'b101: return 3'd7;
      default:        return 3'd0;
    endcase
  endfunction

  function automatic logic [10:0] next_addr(input logic [10:0] a, input logic [2:0] b);
    case (b)
      3'b010:  return {a[10:2], a[1:0] + 2'd1};
      3'b100:  return {a[10:3], a[2:0] + 3'd1};
      default: return a + 11'd1;
    endcase
  endfunction

  assign entry      = cmd_table[ptr];
  assign accept     = (state == BEAT) && hready;
  assign final_beat = accept && (beat_cnt == 3'd0);
  assign seq_end    = final_beat && cur_last;
  assign valid      = (state == BEAT);
  assign busy       = (state != IDLE);

  always_ff @(posedge hclk) begin
    if (hreset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = BEAT;
      BEAT: begin
        if (final_beat) begin
          if (!cur_last || LOOP_EN) state_next = LOAD;
          else                      state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The table survives reset so software only reprograms changed entries.
  always_ff @(posedge hclk) begin
    if (cmd_we && !busy) cmd_table[cmd_idx] <= cmd_wdata;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      data      <= '0;
      address   <= '0;
      write     <= 1'b0;
      bursttype <= '0;
      done      <= 1'b0;
      rd_sum    <= '0;
      ptr       <= '0;
      beat_cnt  <= '0;
      cur_last  <= 1'b0;
      pending   <= 1'b0;
    end else begin
      done <= seq_end;

      // Read data trails its accepting edge by one hready cycle.
      if (state == IDLE && start)  rd_sum <= '0;
      else if (pending && hready) rd_sum <= rd_sum + rdata;

      if (accept && !write) pending <= 1'b1;
      else if (hready)      pending <= 1'b0;

      case (state)
        IDLE: if (start) ptr <= '0;
        LOAD: begin
          address   <= entry[18:8];
          data      <= entry[7:0];
          write     <= entry[22];
          bursttype <= entry[21:19];
          beat_cnt  <= beats_minus_one(entry[21:19]);
          cur_last  <= entry[23] || (ptr == 4'd15);
        end
        BEAT: begin
          if (accept) begin
            if (beat_cnt != 3'd0) begin
              address  <= next_addr(address, bursttype);
              data     <= data + 8'd1;
              beat_cnt <= beat_cnt - 3'd1;
            end else if (!cur_last) begin
              ptr <= ptr + 4'd1;
            end else if (LOOP_EN) begin
              ptr <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
